// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
// APB-style instruction memory bus between the fetch unit and instruction
// memory.
//   paddr   : word-aligned fetch address (master -> slave)
//   psel    : select (master -> slave)
//   penable : enable / access phase (master -> slave)
//   prdata  : fetched word, slot 0 in the MSBs (slave -> master)
//   pvalid  : transfer complete, prdata valid (slave -> master)
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pvalid;

    modport master (
        output paddr, psel, penable,
        input  prdata, pvalid
    );

    modport slave (
        input  paddr, psel, penable,
        output prdata, pvalid
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Instruction fetch unit and prefetch queue. Keeps one memory request
// outstanding, unpacks each fetched word into IPW instructions and buffers
// {instruction, PC} pairs in a circular queue feeding decode.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   stall_flg     : decode stall, blocks pops only
//   redirect      : flush queue and restart fetch at redirect_pc
//   redirect_pc   : new instruction-aligned byte PC
//   bus (master)  : APB-style memory bus (paddr/psel/penable/prdata/pvalid)
//   inst, inst_pc : head instruction and its byte PC (0 when empty)
//   inst_valid    : head valid
//   q_count       : occupied queue entries
//
// Optional feature macro: FETCH_BYPASS_EN. When defined, a word arriving on
// an empty queue drives its first usable slot straight to decode in the same
// cycle; if decode takes it, it is not stored.
//
// Fetch FSM states:
//   state  | meaning
//   IDLE   | no request on the bus, waiting for room in the queue
//   SETUP  | psel=1, penable=0, one cycle
//   ACCESS | psel=1, penable=1, waiting for pvalid
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 16,
    parameter int              IPW      = 2,
    parameter int              DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_flg,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    inst_fetch_queue_if.master         bus,
    output logic [INST_W-1:0]          inst,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    localparam int INST_BYTES = INST_W / 8;
    localparam int WORD_BYTES = IPW * INST_BYTES;
    localparam int BYTE_SH    = $clog2(INST_BYTES);
    localparam int SLOT_W     = (IPW > 1) ? $clog2(IPW) : 1;
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_BYTES - 1));

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   paddr_r;
    logic                psel_r;
    logic                penable_r;
    logic [ADDR_W-1:0]   fetch_pc;
    logic                squash;

    logic [INST_W-1:0]   inst_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      free;

    logic                write_fire;
    logic                pop_q;
    logic                byp_act;
    logic                skip;
    logic [SLOT_W-1:0]   start_slot;
    logic [INST_W-1:0]   slot_inst [IPW];
    logic [ADDR_W-1:0]   slot_pc   [IPW];
    logic                slot_we   [IPW];
    logic [PTR_W-1:0]    slot_idx  [IPW];
    logic [CNT_W-1:0]    n_store;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    assign bus.paddr   = paddr_r;
    assign bus.psel    = psel_r;
    assign bus.penable = penable_r;
    assign q_count     = count;

    assign free = (CNT_W+1)'(DEPTH) - {1'b0, count};

    // Offset of the first wanted slot within the fetched word.
    if (IPW > 1) begin : g_slot
        assign start_slot = fetch_pc[BYTE_SH +: SLOT_W];
    end else begin : g_noslot
        assign start_slot = '0;
    end

    // A squashed or redirected transfer never reaches the queue.
    assign write_fire = (state == ACCESS) && bus.pvalid && !squash && !redirect && !rst;
    assign pop_q      = (count != '0) && !stall_flg;

`ifdef FETCH_BYPASS_EN
    assign byp_act = write_fire && (count == '0);
    assign skip    = byp_act && !stall_flg;
`else
    assign byp_act = 1'b0;
    assign skip    = 1'b0;
`endif

    always_comb begin
        n_store = '0;
        for (int k = 0; k < IPW; k++) begin
            slot_inst[k] = bus.prdata[(IPW-1-k)*INST_W +: INST_W];
            slot_pc[k]   = paddr_r + ADDR_W'(k * INST_BYTES);
            slot_idx[k]  = wr_ptr + PTR_W'(k) - PTR_W'(start_slot) - PTR_W'(skip);
            slot_we[k]   = 1'b0;
            if (write_fire &&
                ((SLOT_W+1)'(k) >= ({1'b0, start_slot} + (SLOT_W+1)'(skip)))) begin
                slot_we[k] = 1'b1;
                n_store    = n_store + CNT_W'(1);
            end
        end
    end

    always_comb begin
        inst       = '0;
        inst_pc    = '0;
        inst_valid = 1'b0;
        if (count != '0) begin
            inst       = inst_mem[rd_ptr];
            inst_pc    = pc_mem[rd_ptr];
            inst_valid = 1'b1;
        end else if (byp_act) begin
            inst       = slot_inst[start_slot];
            inst_pc    = slot_pc[start_slot];
            inst_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < IPW; k++) begin
            if (slot_we[k]) begin
                inst_mem[slot_idx[k]] <= slot_inst[k];
                pc_mem[slot_idx[k]]   <= slot_pc[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_store);
            rd_ptr <= rd_ptr + PTR_W'(pop_q);
            count  <= count + n_store - CNT_W'(pop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            paddr_r   <= RESET_PC;
            fetch_pc  <= RESET_PC;
            squash    <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end
            case (state)
                IDLE: begin
                    // Flushed queue always has room, so a redirect issues at once.
                    if (redirect) begin
                        state   <= SETUP;
                        psel_r  <= 1'b1;
                        paddr_r <= word_align(redirect_pc);
                    end else if (free >= (CNT_W+1)'(IPW)) begin
                        state   <= SETUP;
                        psel_r  <= 1'b1;
                        paddr_r <= word_align(fetch_pc);
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_r <= 1'b1;
                    if (redirect) begin
                        squash <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (bus.pvalid) begin
                        squash <= 1'b0;
                        if (redirect || squash) begin
                            state     <= IDLE;
                            psel_r    <= 1'b0;
                            penable_r <= 1'b0;
                        end else begin
                            fetch_pc <= paddr_r + ADDR_W'(WORD_BYTES);
                            // Back-to-back issue only if the next word surely fits.
                            if (free >= (CNT_W+1)'(2 * IPW)) begin
                                state     <= SETUP;
                                penable_r <= 1'b0;
                                paddr_r   <= paddr_r + ADDR_W'(WORD_BYTES);
                            end else begin
                                state     <= IDLE;
                                psel_r    <= 1'b0;
                                penable_r <= 1'b0;
                            end
                        end
                    end else if (redirect) begin
                        squash <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed bench for inst_fetch_queue with default parameters
// (ADDR_W=32, INST_W=16, IPW=2, DEPTH=8, RESET_PC=0) and a small memory
// responder with a programmable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_flg;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [3:0]  q_count;

    int n_cmp = 0;
    int n_fail = 0;
    int wait_cycles = 0;
    int acc_cnt = 0;

    inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch_queue #(
        .ADDR_W(32), .INST_W(16), .IPW(2), .DEPTH(8), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_flg(stall_flg),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .bus(bus),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_valid(inst_valid),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Instruction stored at a byte PC: the first word is 0xAAAA_BBBB,
    // everything else encodes its own PC.
    function automatic logic [15:0] exp_inst(input logic [31:0] pc);
        if (pc == 32'h0) return 16'hAAAA;
        if (pc == 32'h2) return 16'hBBBB;
        return 16'hC000 | {4'h0, pc[11:0]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {exp_inst(addr), exp_inst(addr + 32'd2)};
    endfunction

    // Memory: pvalid after wait_cycles ACCESS cycles without pvalid.
    always @(posedge clk) begin
        #2;
        if (bus.psel && bus.penable) begin
            if (acc_cnt >= wait_cycles) begin
                bus.pvalid = 1'b1;
                bus.prdata = mem_word(bus.paddr);
            end else begin
                bus.pvalid = 1'b0;
                bus.prdata = 32'h0;
            end
            acc_cnt++;
        end else begin
            bus.pvalid = 1'b0;
            bus.prdata = 32'h0;
            acc_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_hold();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        stall_flg = 1'b0;

        // ---- cold fetch, zero wait ----
        wait_cycles = 0;
        reset_hold();
        chk("rst_psel", {31'h0, bus.psel}, 32'h0);
        chk("rst_penable", {31'h0, bus.penable}, 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", {16'h0, inst}, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_count", {28'h0, q_count}, 32'h0);
        rst = 1'b0;                                    // cycle 0
        chk("c0_psel", {31'h0, bus.psel}, 32'h0);
        tick();                                        // cycle 1
        chk("c1_psel", {31'h0, bus.psel}, 32'h1);
        chk("c1_penable", {31'h0, bus.penable}, 32'h0);
        chk("c1_paddr", bus.paddr, 32'h0);
        tick();                                        // cycle 2
        chk("c2_penable", {31'h0, bus.penable}, 32'h1);
        chk("c2_valid", {31'h0, inst_valid}, 32'h0);
        tick();                                        // cycle 3
        chk("c3_valid", {31'h0, inst_valid}, 32'h1);
        chk("c3_inst", {16'h0, inst}, 32'h0000_AAAA);
        chk("c3_pc", inst_pc, 32'h0);
        tick();                                        // cycle 4
        chk("c4_inst", {16'h0, inst}, 32'h0000_BBBB);
        chk("c4_pc", inst_pc, 32'h2);
        tick();                                        // cycle 5
        chk("c5_inst", {16'h0, inst}, 32'h0000_C004);
        chk("c5_pc", inst_pc, 32'h4);

        // ---- fill under stall, then drain in order ----
        stall_flg = 1'b1;
        reset_hold();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (q_count == 4'd8) break;
            tick();
        end
        chk("fill_count", {28'h0, q_count}, 32'd8);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | bus.psel;
            tick();
        end
        chk("full_psel", {31'h0, seen}, 32'h0);
        chk("full_count", {28'h0, q_count}, 32'd8);
        stall_flg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", inst_pc, 32'(2 * i));
            chk("drain_inst", {16'h0, inst}, {16'h0, exp_inst(32'(2 * i))});
            tick();
        end

        // ---- redirect during ACCESS ----
        stall_flg = 1'b1;
        wait_cycles = 2;
        reset_hold();
        rst = 1'b0;                                    // cycle 0
        tick();                                        // cycle 1
        tick();                                        // cycle 2, ACCESS
        chk("redir_in_access", {31'h0, bus.penable}, 32'h1);
        redirect = 1'b1;
        redirect_pc = 32'h12;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'h0, inst_valid}, 32'h0);
        chk("redir_count", {28'h0, q_count}, 32'h0);
        chk("redir_hold_penable", {31'h0, bus.penable}, 32'h1);
        chk("redir_hold_paddr", bus.paddr, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (bus.psel && !bus.penable) break;
            tick();
        end
        chk("redir_setup_psel", {31'h0, bus.psel & ~bus.penable}, 32'h1);
        chk("redir_paddr", bus.paddr, 32'h10);
        chk("redir_squashed", {28'h0, q_count}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (inst_valid) break;
            tick();
        end
        chk("redir_first_valid", {31'h0, inst_valid}, 32'h1);
        chk("redir_first_pc", inst_pc, 32'h12);
        chk("redir_first_inst", {16'h0, inst}, 32'h0000_C012);
        chk("redir_slot_drop", {28'h0, q_count}, 32'h1);

        // ---- redirect from idle to PC 2, pointer wrap with pop + write ----
        wait_cycles = 0;
        stall_flg = 1'b1;
        reset_hold();
        rst = 1'b0;                                    // cycle 0
        redirect = 1'b1;
        redirect_pc = 32'h2;
        tick();                                        // cycle 1
        redirect = 1'b0;
        chk("idle_redir_psel", {31'h0, bus.psel}, 32'h1);
        chk("idle_redir_paddr", bus.paddr, 32'h0);
        for (int i = 0; i < 30; i++) begin
            if (q_count == 4'd7) break;
            tick();
        end
        chk("odd_fill_count", {28'h0, q_count}, 32'd7);
        chk("odd_head_pc", inst_pc, 32'h2);
        tick();
        tick();
        chk("odd_full_psel", {31'h0, bus.psel}, 32'h0);
        wait_cycles = 1;
        stall_flg = 1'b0;                              // cycle A
        tick();                                        // A+1
        tick();                                        // A+2
        chk("wrap_setup", {31'h0, bus.psel & ~bus.penable}, 32'h1);
        chk("wrap_paddr", bus.paddr, 32'h10);
        tick();                                        // A+3
        tick();                                        // A+4, pvalid
        chk("wrap_count_before", {28'h0, q_count}, 32'd3);
        chk("wrap_access", {31'h0, bus.penable}, 32'h1);
        tick();                                        // A+5
        chk("wrap_count_after", {28'h0, q_count}, 32'd4);
        for (int i = 0; i < 6; i++) begin
            chk("wrap_pc", inst_pc, 32'(12 + 2 * i));
            chk("wrap_inst", {16'h0, inst}, {16'h0, exp_inst(32'(12 + 2 * i))});
            tick();
        end

        // ---- wait states hold the bus, reset mid-ACCESS ----
        stall_flg = 1'b1;
        wait_cycles = 3;
        reset_hold();
        rst = 1'b0;                                    // cycle 0
        tick();                                        // cycle 1
        for (int i = 0; i < 3; i++) begin
            tick();                                    // cycles 2..4
            chk("wait_psel", {31'h0, bus.psel}, 32'h1);
            chk("wait_penable", {31'h0, bus.penable}, 32'h1);
            chk("wait_paddr", bus.paddr, 32'h0);
        end
        tick();                                        // cycle 5, pvalid arrives
        rst = 1'b1;
        tick();
        chk("midrst_psel", {31'h0, bus.psel}, 32'h0);
        chk("midrst_penable", {31'h0, bus.penable}, 32'h0);
        chk("midrst_count", {28'h0, q_count}, 32'h0);
        chk("midrst_valid", {31'h0, inst_valid}, 32'h0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
